// File: rtl/clk_div_checker.sv
// Measures one period and its high time of a divided clock in clki cycles and
// compares them with an expected power-of-two ratio; aborts on a stuck clock.
module clk_div_checker #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             mon_clk,
    input  logic             start,
    input  logic [1:0]       exp_div,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             match,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_WAIT = CNT_W'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl, lvl_d_q, rise;
    logic [1:0]             exp_q, exp_d;
    logic [CNT_W-1:0]       tcnt_q, tcnt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hi_q, hi_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   match_q, match_d;
    logic                   timeout_q, timeout_d;
    logic                   done_q, done_d;
    logic                   finish, abort;

    function automatic logic ratio_ok(input logic [CNT_W-1:0] per,
                                      input logic [CNT_W-1:0] hi,
                                      input logic [1:0]       e);
        return (32'(per) == (32'd2 << e)) && (32'(hi) == (32'd1 << e));
    endfunction

    // mon_clk is asynchronous to clki, so it is only used after the sampling chain
    generate
        if (SYNC_STAGES > 1) begin : g_chain
            always_ff @(posedge clki or posedge rst) begin
                if (rst) sync_q <= '0;
                else     sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk};
            end
        end else begin : g_single
            always_ff @(posedge clki or posedge rst) begin
                if (rst) sync_q <= '0;
                else     sync_q <= mon_clk;
            end
        end
    endgenerate

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = lvl & ~lvl_d_q;

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lvl_d_q   <= 1'b0;
            exp_q     <= '0;
            tcnt_q    <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lvl_d_q   <= lvl;
            exp_q     <= exp_d;
            tcnt_q    <= tcnt_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            period_q  <= period_d;
            high_q    <= high_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        tcnt_d    = tcnt_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        period_d  = period_q;
        high_d    = high_q;
        match_d   = match_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d   = exp_div;
                    tcnt_d  = '0;
                    state_d = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (rise) begin
                    cnt_d   = ONE;
                    hi_d    = ONE;
                    state_d = MEASURE;
                end else if (tcnt_q == TMO_WAIT) begin
                    abort = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + ONE;
                end
            end
            MEASURE: begin
                // the rise cycle itself belongs to the next period, so it is not counted here
                if (rise) begin
                    finish = 1'b1;
                end else if (cnt_q == TMO_CNT) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                    hi_d  = hi_q + CNT_W'(lvl);
                end
            end
            default: state_d = IDLE;
        endcase
        if (finish) begin
            period_d  = cnt_q;
            high_d    = hi_q;
            match_d   = ratio_ok(cnt_q, hi_q, exp_q);
            timeout_d = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
        end
        if (abort) begin
            period_d  = '0;
            high_d    = '0;
            match_d   = 1'b0;
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = IDLE;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign period   = period_q;
    assign high_cnt = high_q;
    assign match    = match_q;
    assign timeout  = timeout_q;
endmodule

// File: tb/tb_clk_div_checker.sv
// Bench for clk_div_checker: waveform-search reference model compared every cycle,
// plus directed scenarios with hand-computed results.
module tb_clk_div_checker;
    localparam int CNT_W = 8;
    localparam int TMO   = 64;
    localparam int SYNC  = 2;
    localparam int HIST  = 4096;

    logic             clki    = 1'b0;
    logic             rst     = 1'b1;
    logic             mon_clk = 1'b0;
    logic             start   = 1'b0;
    logic [1:0]       exp_div = 2'd0;
    logic             busy, done, match, timeout;
    logic [CNT_W-1:0] period, high_cnt;

    int checks = 0;
    int errors = 0;

    clk_div_checker #(.CNT_W(CNT_W), .TIMEOUT(TMO), .SYNC_STAGES(SYNC)) dut (
        .clki(clki), .rst(rst), .mon_clk(mon_clk), .start(start), .exp_div(exp_div),
        .busy(busy), .done(done), .period(period), .high_cnt(high_cnt),
        .match(match), .timeout(timeout)
    );

    always #5 clki = ~clki;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end
    endtask

    // Monitored clock source: 0 = pattern of mon_hi high / mon_lo low, 1 = stuck 0, 2 = stuck 1
    int mon_mode = 1, mon_hi = 2, mon_lo = 2, ph = 0;
    always @(negedge clki) begin
        if (mon_mode == 0) begin
            ph      = (ph + 1) % (mon_hi + mon_lo);
            mon_clk = (ph < mon_hi);
        end else begin
            mon_clk = (mon_mode == 2);
        end
    end

    // Reference model: mon_at[e] is mon_clk seen at clock edge e; the sampled
    // level in cycle k is that value SYNC-1 edges older, zero across a reset.
    bit mon_at [HIST];
    int e = 0, rst_edge = 0;
    bit m_busy = 1'b0, m_done = 1'b0, m_match = 1'b0, m_tmo = 1'b0;
    int m_a = 0, m_exp = 0, m_per = 0, m_hi = 0;

    function automatic bit lv(input int k);
        int j = k - SYNC + 1;
        if (j <= rst_edge || j < 0 || j >= HIST) return 1'b0;
        return mon_at[j];
    endfunction

    function automatic bit rs(input int k);
        return lv(k) && !lv(k - 1);
    endfunction

    function automatic int first_rise(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) if (rs(k)) return k;
        return -1;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_abort();
        m_per = 0; m_hi = 0; m_match = 1'b0; m_tmo = 1'b1; m_done = 1'b1; m_busy = 1'b0;
    endtask

    always @(posedge clki) begin
        int r1, r2;
        e++;
        if (e < HIST) mon_at[e] = mon_clk;
        m_done = 1'b0;
        if (rst) begin
            rst_edge = e;
            m_busy = 1'b0; m_per = 0; m_hi = 0; m_match = 1'b0; m_tmo = 1'b0;
        end else if (m_busy) begin
            // transaction accepted in cycle m_a; the last busy cycle is e-1
            r1 = first_rise(m_a + 1, min2(e - 1, m_a + TMO));
            if (r1 < 0) begin
                if (e - 1 == m_a + TMO) model_abort();
            end else begin
                r2 = first_rise(r1 + 1, min2(e - 1, r1 + TMO));
                if (r2 >= 0 && r2 == e - 1) begin
                    m_per = r2 - r1;
                    m_hi  = 0;
                    for (int k = r1; k < r2; k++) m_hi += int'(lv(k));
                    m_match = (m_per == (2 << m_exp)) && (m_hi == (1 << m_exp));
                    m_tmo   = 1'b0;
                    m_done  = 1'b1;
                    m_busy  = 1'b0;
                end else if (r2 < 0 && e - 1 == r1 + TMO) begin
                    model_abort();
                end
            end
        end else if (start) begin
            m_busy = 1'b1;
            m_a    = e - 1;
            m_exp  = int'(exp_div);
        end
        #1;
        chk("busy",     int'(busy),     int'(m_busy));
        chk("done",     int'(done),     int'(m_done));
        chk("period",   int'(period),   m_per);
        chk("high_cnt", int'(high_cnt), m_hi);
        chk("match",    int'(match),    int'(m_match));
        chk("timeout",  int'(timeout),  int'(m_tmo));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clki);
    endtask

    task automatic do_start(input logic [1:0] ed);
        exp_div = ed;
        start   = 1'b1;
        @(negedge clki);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clki);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_wait actual=no_done required=done_within_400", name);
        end
    endtask

    task automatic check_result(input string name, input int per, input int hi,
                                input int m, input int t);
        chk({name, "_period"},   int'(period),   per);
        chk({name, "_high_cnt"}, int'(high_cnt), hi);
        chk({name, "_match"},    int'(match),    m);
        chk({name, "_timeout"},  int'(timeout),  t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, p_seen, h_seen, m_seen;
        p_seen = -1; h_seen = -1; m_seen = -1;

        cyc(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        check_result("rst", 0, 0, 0, 0);
        rst = 1'b0;
        cyc(2);

        // /4 square wave
        mon_hi = 2; mon_lo = 2; mon_mode = 0;
        cyc(4);
        do_start(2'd1);
        wait_done("div4");
        check_result("div4", 4, 2, 1, 0);

        // /16 then back-to-back /2
        mon_hi = 8; mon_lo = 8;
        cyc(2);
        do_start(2'd3);
        wait_done("div16");
        check_result("div16", 16, 8, 1, 0);
        mon_hi = 1; mon_lo = 1;
        do_start(2'd0);
        chk("b2b_busy", int'(busy), 1);
        wait_done("div2");
        check_result("div2", 2, 1, 1, 0);

        // /8 with 3 high / 5 low, against two expectations
        mon_hi = 3; mon_lo = 5;
        cyc(2);
        do_start(2'd2);
        wait_done("duty35_e2");
        check_result("duty35_e2", 8, 3, 0, 0);
        do_start(2'd1);
        wait_done("duty35_e1");
        check_result("duty35_e1", 8, 3, 0, 0);

        // stuck low: timeout in WAIT_EDGE exactly TMO cycles after busy rises
        mon_mode = 1;
        cyc(6);
        do_start(2'd0);
        chk("stuck0_busy", int'(busy), 1);
        n = 0;
        while (!done && n < 200) begin
            cyc(1);
            n++;
        end
        chk("stuck0_latency", n, 64);
        check_result("stuck0", 0, 0, 0, 1);

        // one rise then stuck high: timeout in MEASURE
        do_start(2'd0);
        cyc(3);
        mon_mode = 2;
        wait_done("stuck1");
        check_result("stuck1", 0, 0, 0, 1);

        // reset mid-measurement
        mon_mode = 1;
        cyc(6);
        do_start(2'd1);
        cyc(3);
        mon_mode = 2;
        cyc(10);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        check_result("mid_rst", 0, 0, 0, 0);
        @(negedge clki);
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clki);
            if (done) n++;
        end
        chk("rst_no_done", n, 0);
        mon_hi = 2; mon_lo = 2; mon_mode = 0;
        cyc(2);
        do_start(2'd1);
        wait_done("post_rst");
        check_result("post_rst", 4, 2, 1, 0);

        // start and exp_div changes while busy are ignored
        mon_hi = 4; mon_lo = 4;
        cyc(2);
        do_start(2'd2);
        for (int i = 0; i < 3; i++) begin
            exp_div = 2'd0;
            start   = 1'b1;
            cyc(1);
            start   = 1'b0;
            cyc(1);
        end
        n = 0;
        repeat (120) begin
            if (done) begin
                n++;
                p_seen = int'(period);
                h_seen = int'(high_cnt);
                m_seen = int'(match);
            end
            cyc(1);
        end
        chk("ign_done_count", n, 1);
        chk("ign_period", p_seen, 8);
        chk("ign_high_cnt", h_seen, 4);
        chk("ign_match", m_seen, 1);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_div_checker.md
# clk_div_checker

Measures a clock produced by the divider, in `clki` cycles, and checks it against an expected divide ratio. It reports period, high time, a match flag and a stuck-clock timeout. It sits beside the divider in the clock/reset subsystem, is sampled synchronously in the `clki` domain, and is used for power-on self-test and for debug readback of the divided clock.

## Interface

Parameters
- `CNT_W`, 8: width of the period, high-time and timeout counters.
- `TIMEOUT`, 64: `clki` cycles without a qualifying edge before the measurement aborts. Legal range is 3 to 2^CNT_W−1.
- `SYNC_STAGES`, 2: sampling flops on `mon_clk`. Minimum 1.

Ports
- `clki`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `mon_clk`  in  1  monitored clock, treated as data. Each high and low phase is at least 1 `clki` cycle.
- `start`  in  1  single-cycle request. Accepted only in IDLE.
- `exp_div`  in  2  expected ratio. 0→/2, 1→/4, 2→/8, 3→/16. Captured when `start` is accepted.
- `busy`  out  1  high while in WAIT_EDGE or MEASURE.
- `done`  out  1  one-cycle pulse when results update.
- `period`  out  CNT_W  measured period in `clki` cycles.
- `high_cnt`  out  CNT_W  `clki` cycles the sampled level was high within that period.
- `match`  out  1  period and duty equal expectation.
- `timeout`  out  1  measurement aborted.

## Operation

Sampling
- `mon_clk` passes through SYNC_STAGES flops to give `lvl`; one more flop gives `lvl_d`.
- `rise = lvl & ~lvl_d`.

FSM states: IDLE, WAIT_EDGE, MEASURE.
- IDLE: on `start`, capture `exp_div` into `exp_q`, clear `tcnt`, go to WAIT_EDGE. `start` is ignored in every other state.
- WAIT_EDGE: on `rise`, set `cnt`←1, `hi`←1 and go to MEASURE. Otherwise increment `tcnt`. If `tcnt` == TIMEOUT−1 on a non-rise cycle, abort.
- MEASURE: on `rise`, latch `period`←`cnt` and `high_cnt`←`hi`, then finish. Otherwise `cnt`←`cnt`+1 and `hi`←`hi`+`lvl`. If `cnt` == TIMEOUT on a non-rise cycle, abort.

Finish
- Pulse `done`, set `timeout`←0, go to IDLE.
- `match`←(`period` == 2^(exp_q+1)) && (`high_cnt` == 2^exp_q), computed from the newly latched values.

Abort
- Pulse `done`, set `timeout`←1.
- Set `period`←0, `high_cnt`←0, `match`←0.
- Go to IDLE.

Arithmetic and holding
- Counters are CNT_W bits. They cannot overflow because TIMEOUT ≤ 2^CNT_W−1 bounds them.
- Results hold until the next finish or abort. A new `start` does not clear them.

## Timing

- Reset values: state IDLE, sync chain 0, `busy` 0, `done` 0, `period` 0, `high_cnt` 0, `match` 0, `timeout` 0.
- `done`, `period`, `high_cnt`, `match` and `timeout` are all registered. They change in the same cycle `done` is high, and that cycle is the first IDLE cycle.
- `start` is accepted in that same cycle, so back-to-back measurements are possible.
- `busy` rises the cycle after `start` is accepted. It falls in the cycle `done` is high.
- Latency:
  - `mon_clk` rising edge to `rise` is SYNC_STAGES+1 cycles.
  - End of the measured period to `done` is SYNC_STAGES+2 cycles.
  - Fixed latency does not bias `period`.
- Period convention: a /2 clock gives `period`=2 and `high_cnt`=1.
- Stuck clocks: a stuck-high or stuck-low `mon_clk` ends in timeout, in WAIT_EDGE or MEASURE.
- `rst` asserted mid-measurement returns everything to reset values immediately. No `done` is produced.
- `exp_div` changing while `busy` has no effect.

## Test plan

- `mon_clk` = /4 square wave (2 high, 2 low), `exp_div`=1, `start` → `done` with `period`=4, `high_cnt`=2, `match`=1, `timeout`=0.
- `mon_clk` = /16, `exp_div`=3, then immediate `start` on `done` with `mon_clk` = /2, `exp_div`=0 → first: 16/8/match=1. Second: 2/1/match=1, and `busy` stays high between runs except in the `done` cycle.
- `mon_clk` = /8, `exp_div`=2 but 3 high / 5 low → `period`=8, `high_cnt`=3, `match`=0. Then same clock with `exp_div`=1 → `period`=8, `high_cnt`=3, `match`=0.
- `mon_clk` held 0, TIMEOUT=64, `start` → `done` exactly 64 cycles after `busy` rises, `timeout`=1, `period`=0. Then stuck 1 after one rise → `timeout` at `cnt`=64.
- `rst` pulsed mid-MEASURE → all outputs 0, state IDLE, no `done`. A following `start` on a /4 clock measures correctly.
- `start` pulses while `busy` → ignored: exactly one `done` per accepted `start`, and results use the `exp_div` captured at acceptance.
